// File: rtl/ext_sram_word_seq.sv
// ext_sram_word_seq: sequences one 32-bit request into byte strobes on an 8-bit external SRAM bus
module ext_sram_word_seq #(
    parameter int ReadLatency = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic [7:0]  ext_sram_rdata_i,
    output logic [7:0]  ext_sram_wdata_o,
    output logic [31:0] ext_sram_addr_o,
    output logic        ext_sram_read_o,
    output logic        ext_sram_write_o
);
    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP} state_t;

    state_t      state, state_d;
    logic [29:0] base, base_d, base_src;
    logic [31:0] wdata_q, wdata_d, wsrc, rdata_d, addr_d;
    logic [3:0]  pend, pend_d, m;
    logic [1:0]  lane, lane_d, cnt, cnt_d, first;
    logic [7:0]  wd_d;
    logic        rd_d, wr_d, rv_d, do_wr;
    logic        unused_addr;

    assign unused_addr = ^addr_i[1:0];

    // Next-state and next-output logic; every SRAM pin and rvalid is computed here one cycle ahead and registered below
    always_comb begin
        gnt_o    = req_i && (state == IDLE);
        state_d  = state;
        base_d   = base;
        wdata_d  = wdata_q;
        pend_d   = pend;
        lane_d   = lane;
        cnt_d    = cnt;
        rdata_d  = rdata_o;
        addr_d   = '0;
        wd_d     = '0;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        rv_d     = 1'b0;
        m        = (state == IDLE) ? be_i : pend;
        wsrc     = (state == IDLE) ? wdata_i : wdata_q;
        base_src = (state == IDLE) ? addr_i[31:2] : base;
        first    = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
        do_wr    = (gnt_o && we_i) || (state == WRITE);
        case (state)
            IDLE: begin
                if (gnt_o) begin
                    base_d  = addr_i[31:2];
                    wdata_d = wdata_i;
                    lane_d  = 2'd0;
                    if (!we_i) begin
                        state_d = RD_ISSUE;
                        rd_d    = 1'b1;
                        addr_d  = {addr_i[31:2], 2'b00};
                    end
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                cnt_d   = 2'(ReadLatency - 1);
            end
            RD_WAIT: begin
                if (cnt == 2'd0) begin
                    rdata_d[{lane, 3'b000} +: 8] = ext_sram_rdata_i;
                    if (lane == 2'd3) begin
                        state_d = RESP;
                        rv_d    = 1'b1;
                    end else begin
                        lane_d  = lane + 2'd1;
                        state_d = RD_ISSUE;
                        rd_d    = 1'b1;
                        addr_d  = {base, lane + 2'd1};
                    end
                end else begin
                    cnt_d = cnt - 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = state;
        endcase
        if (do_wr) begin
            if (m != 4'b0000) begin
                state_d = WRITE;
                wr_d    = 1'b1;
                addr_d  = {base_src, first};
                wd_d    = wsrc[{first, 3'b000} +: 8];
                pend_d  = m & ~(4'b0001 << first);
            end else begin
                state_d = RESP;
                rv_d    = 1'b1;
            end
        end
    end

    // State, latched request and registered outputs; reset aborts any request in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            base             <= '0;
            wdata_q          <= '0;
            pend             <= '0;
            lane             <= '0;
            cnt              <= '0;
            rdata_o          <= '0;
            rvalid_o         <= 1'b0;
            ext_sram_addr_o  <= '0;
            ext_sram_wdata_o <= '0;
            ext_sram_read_o  <= 1'b0;
            ext_sram_write_o <= 1'b0;
        end else begin
            state            <= state_d;
            base             <= base_d;
            wdata_q          <= wdata_d;
            pend             <= pend_d;
            lane             <= lane_d;
            cnt              <= cnt_d;
            rdata_o          <= rdata_d;
            rvalid_o         <= rv_d;
            ext_sram_addr_o  <= addr_d;
            ext_sram_wdata_o <= wd_d;
            ext_sram_read_o  <= rd_d;
            ext_sram_write_o <= wr_d;
        end
    end
endmodule
